// File: rtl/io_periph.sv
// io_periph: memory-mapped board I/O (LEDs, seven-segment digits, debounced switches, cycle timer)
// Rev 1.0 - initial release
`default_nettype none

module io_periph #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wren,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     HEX_RST  = 32'h7F7F7F7F;

  logic [31:0] ledr, ledg, hexlo, hexhi, timer;
  logic [31:0] sync1, sync2, sync2_prev, sw_stable;
  logic [CNT_W-1:0] cnt;

  // Only the 4 KiB page number selects a register; the page offset is don't-care.
  logic [19:0] page;
  logic        sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_sw, sel_timer;
  logic        unused_addr;

  assign page        = i_addr[31:12];
  assign unused_addr = ^i_addr[11:0];
  assign sel_ledr    = (page == 20'h10000);
  assign sel_ledg    = (page == 20'h10001);
  assign sel_hexlo   = (page == 20'h10002);
  assign sel_hexhi   = (page == 20'h10003);
  assign sel_sw      = (page == 20'h10010);
  assign sel_timer   = (page == 20'h10012);
  assign o_hit       = sel_ledr | sel_ledg | sel_hexlo | sel_hexhi | sel_sw | sel_timer;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr  <= '0;
      ledg  <= '0;
      hexlo <= HEX_RST;
      hexhi <= HEX_RST;
      timer <= '0;
    end else begin
      if (i_wren && sel_ledr)  ledr  <= be_merge(ledr, i_wdata, i_be);
      if (i_wren && sel_ledg)  ledg  <= be_merge(ledg, i_wdata, i_be);
      // Segment bit 7 of each byte has no digit behind it, so it is held at 0.
      if (i_wren && sel_hexlo) hexlo <= be_merge(hexlo, i_wdata, i_be) & HEX_RST;
      if (i_wren && sel_hexhi) hexhi <= be_merge(hexhi, i_wdata, i_be) & HEX_RST;
      if (i_wren && sel_timer) timer <= i_wdata;
      else                     timer <= timer + 32'd1;
    end
  end

  // Two-flop synchroniser followed by a whole-vector debounce qualifier.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync2_prev <= '0;
      sw_stable  <= '0;
      cnt        <= '0;
    end else begin
      sync1      <= i_io_sw;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (sync2 != sync2_prev) begin
        cnt <= '0;
      end else if (sync2 == sw_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (sel_ledr)       o_rdata = ledr;
    else if (sel_ledg)  o_rdata = ledg;
    else if (sel_hexlo) o_rdata = hexlo;
    else if (sel_hexhi) o_rdata = hexhi;
    else if (sel_sw)    o_rdata = sw_stable;
    else if (sel_timer) o_rdata = timer;
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_hex0 = hexlo[6:0];
  assign o_io_hex1 = hexlo[14:8];
  assign o_io_hex2 = hexlo[22:16];
  assign o_io_hex3 = hexlo[30:24];
  assign o_io_hex4 = hexhi[6:0];
  assign o_io_hex5 = hexhi[14:8];
  assign o_io_hex6 = hexhi[22:16];
  assign o_io_hex7 = hexhi[30:24];

endmodule

`default_nettype wire

// File: doc/io_periph.md
Name: io_periph

Overview:
- Memory-mapped I/O peripheral unit that sits directly downstream of the core's load/store unit.
- Receives the LSU address, write data, write enable and byte enables.
- Returns read data combinationally, matching the single-cycle load path.
- Owns the board-facing registers: red LEDs, green LEDs, eight seven-segment digits, a synchronised and debounced switch input, and a free-running cycle timer.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a switch change is accepted; legal range 2..65535.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_addr  in  32  byte address from LSU (ALU result)
- i_wdata  in  32  store data (rs2, already lane-aligned by LSU)
- i_wren  in  1  store strobe, single cycle, committed at posedge
- i_be  in  4  byte enables for the store; bit n enables i_wdata[8n+7:8n]
- o_rdata  out  32  combinational read data
- o_hit  out  1  combinational: i_addr decodes to an I/O register
- i_io_sw  in  32  raw asynchronous switch inputs
- o_io_ledr  out  32  LEDR register
- o_io_ledg  out  32  LEDG register
- o_io_hex0..o_io_hex7  out  7 each  segment pattern, active-low

Behaviour:
- Decode uses i_addr[31:12] only; i_addr[11:0] are ignored.
  - 0x10000: LEDR, R/W
  - 0x10001: LEDG, R/W
  - 0x10002: HEXLO, R/W; byte n -> hex n (n=0..3)
  - 0x10003: HEXHI, R/W; byte n -> hex n+4
  - 0x10010: SW, read-only, debounced value
  - 0x10012: TIMER, R/W
- Any other address: o_hit=0 and o_rdata=0; writes are ignored.
- Reads are purely combinational from current register state; zero latency.
- A read in the same cycle as a write to the same register returns the old value.
- Writes take effect at the posedge where i_wren=1 and o_hit=1.
  - LEDR, LEDG: byte-enable merge.
  - HEX registers: byte-enable merge, storing bits [6:0] of each enabled byte. Bit 7 of each byte is not stored and reads 0.
  - TIMER: loads the full i_wdata, ignoring i_be. The increment is suppressed in that cycle.
  - SW: writes are ignored. SW state is unaffected.
- Reset values (async, immediate on i_reset=1):
  - LEDR=0, LEDG=0
  - HEXLO=HEXHI=0x7F7F7F7F (all segments off); o_io_hexN=7'h7F
  - TIMER=0
  - sync1, sync2, sync2_prev, sw_stable all 0; debounce counter 0
- TIMER: +1 every cycle when not being written; wraps 0xFFFFFFFF -> 0x00000000.
- Switch path: two-flop synchroniser sync1 -> sync2, then debounce, evaluated each posedge in priority order:
  - if sync2 != sync2_prev: cnt<=0
  - else if sync2 == sw_stable: cnt<=0
  - else if cnt == DEBOUNCE_CYCLES-1: sw_stable<=sync2, cnt<=0
  - else: cnt<=cnt+1
  - sync2_prev<=sync2 always.
- Latency: an i_io_sw step sampled at edge 1 becomes visible in SW reads after edge 3+DEBOUNCE_CYCLES.
- Any sync2 change during counting restarts qualification.
- Counter width is ceil(log2(DEBOUNCE_CYCLES)).
- Reset asserted mid-count discards the pending switch value and returns all state to reset values.
- o_io_* outputs are driven directly from their registers; no extra output pipeline stage.

Test Plan:
- Reset then idle: ledr=ledg=0, all hex=7'h7F, and a TIMER read returns N after N edges past reset release.
- Store 0xDEADBEEF to 0x10000004 with i_be=4'b0101 after LEDR=0: LEDR=0x00AD00EF. A read of 0x10000000 returns 0x00AD00EF and o_hit=1.
- Store 0xFFFFFFFF to HEXHI with i_be=4'b1000, then 0x00000040 to HEXLO with i_be=4'b0001:
  - o_io_hex7=7'h7F and reads as 0x7F7F7F7F
  - o_io_hex0=7'h40
- DEBOUNCE_CYCLES=4, i_io_sw steps 0 -> 0x0000000A before edge 1: SW read is 0 through edge 6 and 0x0A after edge 7.
  - Same setup, but the input toggles back for one cycle at edge 4: acceptance is delayed by the restart.
- TIMER write of 0xFFFFFFFE: reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on successive cycles.
- Store to 0x10010000 (SW) and to 0x20000000: no register changes; 0x20000000 gives o_hit=0 and o_rdata=0.
- Assert i_reset mid-debounce and mid-operation: all outputs return to reset values asynchronously, without waiting for a clock edge.
